// File: rtl/noc_nsu_pkt_arbiter_if.sv
// noc_nsu_pkt_arbiter_if: source flit bundle and NSU-side flit/status bus for the packet arbiter
interface noc_nsu_pkt_arbiter_if #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 4,
  parameter int SRC_W      = 2
);
  logic [NUM_SRC-1:0]            src_valid;
  logic [NUM_SRC-1:0]            src_head;
  logic [NUM_SRC-1:0]            src_tail;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]            src_ready;
  logic [DATA_WIDTH:0]           noc2axi_data;
  logic                          s_is_head;
  logic                          s_is_tail;
  logic                          nsu_busy;
  logic [SRC_W-1:0]              grant_id;
  logic                          pkt_active;
  logic                          proto_err;
  modport master (
    output src_valid, src_head, src_tail, src_data, nsu_busy,
    input  src_ready, noc2axi_data, s_is_head, s_is_tail, grant_id, pkt_active, proto_err
  );
  modport slave (
    input  src_valid, src_head, src_tail, src_data, nsu_busy,
    output src_ready, noc2axi_data, s_is_head, s_is_tail, grant_id, pkt_active, proto_err
  );
endinterface

// File: rtl/noc_nsu_pkt_arbiter.sv
// noc_nsu_pkt_arbiter: packet-atomic round-robin arbiter feeding the single NSU flit input
module noc_nsu_pkt_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SRC    = 4,
  parameter int SRC_W      = 2,
  parameter int MAX_FLITS  = 258,
  parameter int CNT_W      = 9
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  noc_nsu_pkt_arbiter_if.slave  bus
);
  typedef enum logic {IDLE, PKT} state_t;
  state_t                state_q, state_d;
  logic [SRC_W-1:0]      rr_q, rr_d, gnt_q, gnt_d, win, sel;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SRC-1:0]    cand, ready;
  logic                  found, acc, hd, tl, err_d, err_q;
  logic [DATA_WIDTH-1:0] pay;
  logic [DATA_WIDTH:0]   data_q, data_d;
  logic                  head_q, head_d, tail_q, tail_d;

  function automatic logic [SRC_W-1:0] wrap(input int x);
    return SRC_W'(x >= NUM_SRC ? x - NUM_SRC : x);
  endfunction

  // round-robin search: descending offsets so the nearest candidate at/after rr_q wins
  always_comb begin
    cand  = bus.src_valid & bus.src_head;
    win   = '0;
    found = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (cand[wrap(int'(rr_q) + k)]) begin
        win   = wrap(int'(rr_q) + k);
        found = 1'b1;
      end
  end

  // handshake, packet lock, framing checks and output-register next state
  always_comb begin
    sel        = (state_q == PKT) ? gnt_q : win;
    ready      = '0;
    ready[sel] = noc_rst_n & ~bus.nsu_busy & ((state_q == PKT) | found);
    acc        = ready[sel] & bus.src_valid[sel];
    hd         = bus.src_head[sel];
    tl         = bus.src_tail[sel];
    pay        = bus.src_data[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
    state_d    = state_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    cnt_d      = cnt_q;
    err_d      = 1'b0;
    if (state_q == IDLE) begin
      err_d = |(bus.src_valid & ~bus.src_head);
      if (acc) begin
        gnt_d   = win;
        cnt_d   = CNT_W'(1);
        rr_d    = tl ? wrap(int'(win) + 1) : rr_q;
        state_d = tl ? IDLE : PKT;
      end
    end else if (acc) begin
      cnt_d = hd ? CNT_W'(1) : (cnt_q == CNT_W'(MAX_FLITS)) ? cnt_q : cnt_q + 1'b1;
      if (tl) begin
        state_d = IDLE;
        rr_d    = wrap(int'(gnt_q) + 1);
        err_d   = hd;
      end else if (hd) begin
        err_d = 1'b1;
      end else if (cnt_d == CNT_W'(MAX_FLITS)) begin
        err_d   = 1'b1;
        state_d = IDLE;
        rr_d    = wrap(int'(gnt_q) + 1);
      end
    end
    data_d = bus.nsu_busy ? data_q : acc ? {1'b1, pay} : '0;
    head_d = bus.nsu_busy ? head_q : acc & hd;
    tail_d = bus.nsu_busy ? tail_q : acc & tl;
  end

  // state and registered NSU-facing outputs; reset drops any packet in flight
  always_ff @(posedge noc_clk or negedge noc_rst_n)
    if (!noc_rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end

  assign bus.src_ready    = ready;
  assign bus.noc2axi_data = data_q;
  assign bus.s_is_head    = head_q;
  assign bus.s_is_tail    = tail_q;
  assign bus.grant_id     = gnt_q;
  assign bus.pkt_active   = (state_q == PKT);
  assign bus.proto_err    = err_q;
endmodule

// File: tb/tb_noc_nsu_pkt_arbiter.sv
// tb_noc_nsu_pkt_arbiter: directed checks of packet locking, round-robin, backpressure, framing errors and reset
module tb_noc_nsu_pkt_arbiter;
  localparam int DW = 128, NS = 4, SW = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  noc_nsu_pkt_arbiter_if #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_W(SW)) bus();
  noc_nsu_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS), .SRC_W(SW), .MAX_FLITS(258), .CNT_W(9)) dut (
    .noc_clk(clk), .noc_rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic h, input logic t, input logic [DW-1:0] d);
    bus.src_valid[i] = v;
    bus.src_head[i]  = h;
    bus.src_tail[i]  = t;
    bus.src_data[i*DW +: DW] = d;
  endtask

  task automatic out(input string tag, input logic v, input logic [DW-1:0] p, input logic h, input logic t);
    chk(tag, {bus.noc2axi_data, bus.s_is_head, bus.s_is_tail}, {v, p, h, t});
  endtask

  initial begin
    bus.src_valid = '0;
    bus.src_head  = '0;
    bus.src_tail  = '0;
    bus.src_data  = '0;
    bus.nsu_busy  = 1'b0;
    tick();
    tick();
    out("rst_out", 0, 0, 0, 0);
    chk("rst_status", {bus.src_ready, bus.grant_id, bus.pkt_active, bus.proto_err}, 8'h00);
    rst_n = 1'b1;
    tick();
    // 1: src0 four-flit packet, one-cycle latency
    drive(0, 1, 1, 0, 128'hA0);
    #1 chk("t1_ready", bus.src_ready, 4'b0001);
    tick();
    out("t1_f0", 1, 128'hA0, 1, 0);
    chk("t1_lock", {bus.grant_id, bus.pkt_active}, 3'b001);
    drive(0, 1, 0, 0, 128'hA1);
    tick();
    out("t1_f1", 1, 128'hA1, 0, 0);
    drive(0, 1, 0, 0, 128'hA2);
    tick();
    out("t1_f2", 1, 128'hA2, 0, 0);
    drive(0, 1, 0, 1, 128'hA3);
    tick();
    out("t1_f3", 1, 128'hA3, 0, 1);
    chk("t1_idle", bus.pkt_active, 1'b0);
    drive(0, 0, 0, 0, 0);
    tick();
    out("t1_bubble", 0, 0, 0, 0);
    // 2: src1 and src2 heads together; src1 packet goes first, src2 waits
    drive(1, 1, 1, 0, 128'hB0);
    drive(2, 1, 1, 0, 128'hC0);
    #1 chk("t2_ready_src1", bus.src_ready, 4'b0010);
    tick();
    out("t2_b0", 1, 128'hB0, 1, 0);
    chk("t2_grant1", bus.grant_id, 2'd1);
    drive(1, 1, 0, 1, 128'hB1);
    #1 chk("t2_src2_held", bus.src_ready, 4'b0010);
    tick();
    out("t2_b1", 1, 128'hB1, 0, 1);
    drive(1, 0, 0, 0, 0);
    #1 chk("t2_ready_src2", bus.src_ready, 4'b0100);
    tick();
    out("t2_c0", 1, 128'hC0, 1, 0);
    chk("t2_grant2", bus.grant_id, 2'd2);
    drive(2, 1, 0, 1, 128'hC1);
    tick();
    out("t2_c1", 1, 128'hC1, 0, 1);
    drive(2, 0, 0, 0, 0);
    // 3: nsu_busy for three cycles mid-packet
    drive(3, 1, 1, 0, 128'hD0);
    tick();
    out("t3_d0", 1, 128'hD0, 1, 0);
    drive(3, 1, 0, 0, 128'hD1);
    bus.nsu_busy = 1'b1;
    #1 chk("t3_busy_ready", bus.src_ready, 4'b0000);
    tick();
    out("t3_hold1", 1, 128'hD0, 1, 0);
    tick();
    out("t3_hold2", 1, 128'hD0, 1, 0);
    tick();
    out("t3_hold3", 1, 128'hD0, 1, 0);
    chk("t3_locked", {bus.grant_id, bus.pkt_active}, 3'b111);
    bus.nsu_busy = 1'b0;
    #1 chk("t3_resume_ready", bus.src_ready, 4'b1000);
    tick();
    out("t3_d1", 1, 128'hD1, 0, 0);
    drive(3, 1, 0, 1, 128'hD2);
    tick();
    out("t3_d2", 1, 128'hD2, 0, 1);
    drive(3, 0, 0, 0, 0);
    // 4: headless valid in IDLE, then single-flit packet
    drive(3, 1, 0, 0, 128'hE0);
    #1 chk("t4_no_ready", bus.src_ready, 4'b0000);
    tick();
    chk("t4_err1", bus.proto_err, 1'b1);
    out("t4_bubble", 0, 0, 0, 0);
    tick();
    chk("t4_err2", bus.proto_err, 1'b1);
    drive(3, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 128'hF0);
    #1 chk("t4_single_ready", bus.src_ready, 4'b0001);
    tick();
    out("t4_single", 1, 128'hF0, 1, 1);
    chk("t4_single_state", {bus.pkt_active, bus.proto_err}, 2'b00);
    drive(0, 0, 0, 0, 0);
    tick();
    // 5: src0 runs past MAX_FLITS without a tail; src1 waits
    drive(0, 1, 1, 0, 128'd1);
    tick();
    chk("t5_grant0", {bus.grant_id, bus.pkt_active}, 3'b001);
    drive(1, 1, 1, 0, 128'hB10);
    for (int n = 2; n <= 257; n++) begin
      drive(0, 1, 0, 0, DW'(n));
      tick();
    end
    chk("t5_f257_state", {bus.pkt_active, bus.proto_err}, 2'b10);
    out("t5_f257", 1, 128'd257, 0, 0);
    drive(0, 1, 0, 0, 128'd258);
    #1 chk("t5_lock_ready", bus.src_ready, 4'b0001);
    tick();
    out("t5_f258", 1, 128'd258, 0, 0);
    chk("t5_abort", {bus.pkt_active, bus.proto_err}, 2'b01);
    drive(0, 1, 0, 0, 128'd259);
    #1 chk("t5_src1_ready", bus.src_ready, 4'b0010);
    tick();
    chk("t5_grant1", bus.grant_id, 2'd1);
    out("t5_b10", 1, 128'hB10, 1, 0);
    chk("t5_state", {bus.pkt_active, bus.proto_err}, 2'b11);
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 0, 1, 128'hB11);
    tick();
    out("t5_b11", 1, 128'hB11, 0, 1);
    chk("t5_closed", {bus.pkt_active, bus.proto_err}, 2'b00);
    drive(1, 0, 0, 0, 0);
    // 6: reset mid-packet with rr_ptr at 3; afterwards src2 wins from rr_ptr 0
    drive(2, 1, 1, 1, 128'hC2);
    #1 chk("t6_src2_ready", bus.src_ready, 4'b0100);
    tick();
    out("t6_c2", 1, 128'hC2, 1, 1);
    drive(2, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 128'hD0);
    tick();
    drive(0, 1, 0, 0, 128'hD1);
    tick();
    out("t6_d1", 1, 128'hD1, 0, 0);
    #2 rst_n = 1'b0;
    #1 out("t6_rst_out", 0, 0, 0, 0);
    chk("t6_rst_status", {bus.src_ready, bus.grant_id, bus.pkt_active, bus.proto_err}, 8'h00);
    drive(0, 0, 0, 0, 0);
    drive(2, 1, 1, 0, 128'hE2);
    drive(3, 1, 1, 0, 128'hE3);
    #1 chk("t6_rst_ready", bus.src_ready, 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    #1 chk("t6_rr0_ready", bus.src_ready, 4'b0100);
    tick();
    chk("t6_grant2", {bus.grant_id, bus.pkt_active}, 3'b101);
    out("t6_e2", 1, 128'hE2, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
